frost32_mem_responder: RTL

//  Memory-side end of the Frost32 CPU data port. Samples a CPU data request
//  (addr, data, access type, access size, req_mem_access), performs the

---
 rtl/frost32_mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/frost32_mem_responder.sv
// Memory-side responder for the Frost32 CPU data port: word RAM with byte lanes and fixed wait states.
// Define FROST32_MEM_RESP_ERR_EN to add out_err, which flags bad sizes and misaligned addresses.
module frost32_mem_responder #(
  parameter int WORD_ADDR_WIDTH = 12,
  parameter int WAIT_STATES     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_mem_access,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_access_type,
  input  logic [1:0]  in_access_size,
  output logic [31:0] out_data,
  output logic        out_done,
  output logic        out_busy
`ifdef FROST32_MEM_RESP_ERR_EN
  ,
  output logic        out_err
`endif
);

  localparam int DEPTH = 1 << WORD_ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_next;
  logic [3:0]                 count, count_next;
  logic [WORD_ADDR_WIDTH+1:0] addr_q;
  logic [31:0]                wdata_q;
  logic                       write_q;
  logic [1:0]                 size_q;
  logic [31:0]                rdata_q;

  logic [31:0] mem [DEPTH];

  logic [WORD_ADDR_WIDTH-1:0] word_idx;
  logic [1:0]  lane;
  logic [3:0]  byte_en;
  logic [4:0]  shift_bits;
  logic [31:0] read_mask;
  logic [31:0] wdata_shifted;
  logic [31:0] read_val;
  logic        bad;
  logic        write_en;

  assign word_idx = addr_q[WORD_ADDR_WIDTH+1:2];
  assign lane     = addr_q[1:0];

  // Lane selection: the misaligned low address bits are dropped by the lane math itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    byte_en    = 4'b0000;
    shift_bits = 5'd0;
    read_mask  = 32'h0000_0000;
    case (size_q)
      2'b00: begin
        byte_en   = 4'b1111;
        read_mask = 32'hFFFF_FFFF;
      end
      2'b01: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        shift_bits = {lane[1], 4'b0000};
        read_mask  = 32'h0000_FFFF;
      end
      2'b10: begin
        byte_en    = 4'b0001 << lane;
        shift_bits = {lane, 3'b000};
        read_mask  = 32'h0000_00FF;
      end
      default: ;
    endcase
  end

`ifdef FROST32_MEM_RESP_ERR_EN
  logic misaligned;
  assign misaligned = ((size_q == 2'b00) && (lane != 2'b00)) ||
                      ((size_q == 2'b01) && lane[0]);
  assign bad = (size_q == 2'b11) || misaligned;
`else
  assign bad = (size_q == 2'b11);
`endif

  assign wdata_shifted = wdata_q << shift_bits;
  assign read_val      = bad ? 32'h0 : ((mem[word_idx] >> shift_bits) & read_mask);
  assign write_en      = (state == S_RESP) && write_q && !bad;

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (in_req_mem_access) begin
          if (WAIT_STATES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            count_next = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (count == 4'd0) state_next = S_RESP;
        else               count_next = count - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == S_IDLE && in_req_mem_access) begin
        addr_q  <= in_addr[WORD_ADDR_WIDTH+1:0];
        wdata_q <= in_data;
        write_q <= in_access_type;
        size_q  <= in_access_size;
      end
      if (state == S_RESP && !write_q) rdata_q <= read_val;
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst and only the control path is cleared.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= wdata_shifted[8*k +: 8];
      end
    end
  end

  // Read data is visible during the done cycle, then held by rdata_q until the next read.
  assign out_data = (state == S_RESP && !write_q) ? read_val : rdata_q;
  assign out_done = (state == S_RESP);
  assign out_busy = (state != S_IDLE);
`ifdef FROST32_MEM_RESP_ERR_EN
  assign out_err  = (state == S_RESP) && bad;
`endif

endmodule
